ceres_ram_arbiter: RTL and testbench
====================================

# ceres_ram_arbiter

Two-master arbiter and sequencer for the main RAM port in the Ceres SoC wrapper. It sits between the address-decoded RAM selects of two bus masters (m0 = CPU iomem port, m1 = DMA/debug loader) and the single synchronous `wrapper_ram` port. It replaces the free-running latency shift register with an explicit FSM. Only one transaction is in flight at a time; round-robin fairness applies on contention, and the configured access latency is enforced.

## Interface
- `RAM_DEPTH`, default 32768: RAM words; address width `AW = $clog2(RAM_DEPTH)`.
- `LATENCY`, default 16: WAIT cycles per access; legal range 1..255 (elaboration error otherwise).
- `BYTE_OFFSET`, default 2: low address bits dropped to form the word index.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; synchronous and active-low.
- `m0_req_i`  in  iomem_req_t  CPU request (`valid`, `addr`, `data`, `rw` byte strobes); `valid` is pre-qualified by the RAM select.
- `m0_res_o`  out  iomem_res_t  CPU response (`ready`, `valid`, `data`).
- `m1_req_i`  in  iomem_req_t  second master request.
- `m1_res_o`  out  iomem_res_t  second master response.
- `ram_addr_o`  out  AW  word address, `addr[BYTE_OFFSET+AW-1:BYTE_OFFSET]`.
- `ram_wdata_o`  out  BLK_SIZE  write data.
- `ram_wstrb_o`  out  BLK_SIZE/8  write strobes; nonzero only in ISSUE.
- `ram_rd_en_o`  out  1  read enable; high only in ISSUE of a read.
- `ram_rdata_i`  in  BLK_SIZE  RAM read data, valid one cycle after ISSUE.
- `busy_o`  out  1  state != IDLE.
- `grant_o`  out  1  index of the owning master (0/1); meaningful when `busy_o` is high.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - If any `mX_req_i.valid` is high, grant one master and latch its addr, data and rw into registers.
  - Assert `mX_res_o.ready` to the granted master only, combinationally, in this cycle.
  - Go to ISSUE.
- Arbitration: `rr_q` holds the preferred master.
  - If only one master is valid, it wins.
  - If both are valid, master `rr_q` wins.
  - On entry to RESP, `rr_q` becomes the non-served master.
  - `rr_q` resets to 0.
- ISSUE (1 cycle):
  - Drive the latched request onto the RAM port.
  - Read when latched `rw == 0`: `ram_rd_en_o=1`, `ram_wstrb_o=0`.
  - Write otherwise: `ram_wstrb_o=rw`, `ram_rd_en_o=0`.
  - Load `cnt_q = LATENCY-1`.
- WAIT (LATENCY cycles):
  - In the first WAIT cycle, capture `ram_rdata_i` into `rdata_q`.
  - Decrement `cnt_q` each cycle; leave WAIT when `cnt_q == 0`.
- RESP (1 cycle):
  - If the owner's `req.valid` is still high, pulse `mX_res_o.valid=1` with `data=rdata_q`.
  - Writes also return `rdata_q`, which holds the pre-write contents; masters ignore it.
  - If the owner dropped `valid` mid-transaction: the RAM access still completes (writes are not cancelled), the response is suppressed, and the FSM returns to IDLE.
- The non-owner sees `ready=0`, `valid=0`, `data=0` for the whole transaction.
- Masters must hold the request stable until `res.valid`. A request still valid in the cycle after RESP is treated as a new request.

## Timing
- Reset (`rst_ni` low at a clock edge) forces:
  - state IDLE, `rr_q=0`, `cnt_q=0`, `rdata_q=0`;
  - all outputs 0 in the following cycle (`ready` included, since no valid is present).
- Reset mid-transaction aborts without a response. If ISSUE was already sampled, the write has landed in RAM.
- Grant in cycle T (IDLE). ISSUE in T+1. WAIT in T+2 .. T+LATENCY+1. RESP in T+LATENCY+2.
- Back-to-back: the next grant happens at the earliest in T+LATENCY+3, giving a throughput of one access per LATENCY+3 cycles.
- When neither master is valid, the FSM stays in IDLE with no RAM activity.

## Structure
- Add to `ceres_param`:
  - `ram_arb_state_e` (IDLE, ISSUE, WAIT, RESP);
  - `RAM_ARB_LAT_W = 8`.
- `iomem_req_t` and `iomem_res_t` are reused unchanged.
- One natural sub-module: `ceres_rr_arb2`, a combinational 2-way round-robin pick (inputs: valids and `rr_q`; outputs: grant valid and index).
- The counter, latches and FSM stay in the top module.

## Test plan
- m0 reads addr 0x8000_0010 at T, RAM word 4 = 0xDEADBEEF, LATENCY=16 → `ram_rd_en_o` at T+1 with `ram_addr_o=4`; `m0_res_o.valid` only at T+18 with data 0xDEADBEEF; m1 outputs stay 0.
- m0 and m1 valid in the same cycle after reset → m0 granted first; m1's ready is held off and m1 is granted in the cycle after m0's RESP; a third simultaneous pair → m0 again.
- m1 writes rw=4'hF, data 0x1234_5678 to word 8, then m0 reads word 8 → RAM strobes seen only in m1's ISSUE; m0 returns 0x1234_5678.
- m0 drops valid during WAIT → no `m0_res_o.valid`; FSM returns to IDLE after the full LATENCY; a pending m1 request is granted the next cycle.
- `rst_ni` asserted low for one cycle during WAIT → `busy_o=0` and no response afterwards; a subsequent m1-only request is granted (`rr_q=0` does not block a lone m1).
- LATENCY=1 → read response exactly 3 cycles after grant, with the correct data captured.

Source files
------------

// File: rtl/ceres_ram_arbiter_pkg.sv
// ceres_ram_arbiter_pkg: shared types and constants for the main RAM arbiter
package ceres_ram_arbiter_pkg;
    localparam int BLK_SIZE      = 32;
    localparam int RAM_ARB_LAT_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} ram_arb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           addr;
        logic [BLK_SIZE-1:0]   data;
        logic [BLK_SIZE/8-1:0] rw;
    } iomem_req_t;

    typedef struct packed {
        logic                ready;
        logic                valid;
        logic [BLK_SIZE-1:0] data;
    } iomem_res_t;
endpackage

// File: rtl/ceres_ram_arbiter_if.sv
// ceres_ram_arbiter_if: master request/response and RAM port bundle of the arbiter
interface ceres_ram_arbiter_if
    import ceres_ram_arbiter_pkg::*;
#(
    parameter int AW = 15
);
    iomem_req_t            m0_req_i;
    iomem_res_t            m0_res_o;
    iomem_req_t            m1_req_i;
    iomem_res_t            m1_res_o;
    logic [AW-1:0]         ram_addr_o;
    logic [BLK_SIZE-1:0]   ram_wdata_o;
    logic [BLK_SIZE/8-1:0] ram_wstrb_o;
    logic                  ram_rd_en_o;
    logic [BLK_SIZE-1:0]   ram_rdata_i;
    logic                  busy_o;
    logic                  grant_o;

    modport slave (
        input  m0_req_i, m1_req_i, ram_rdata_i,
        output m0_res_o, m1_res_o, ram_addr_o, ram_wdata_o, ram_wstrb_o, ram_rd_en_o, busy_o, grant_o
    );

    modport master (
        output m0_req_i, m1_req_i, ram_rdata_i,
        input  m0_res_o, m1_res_o, ram_addr_o, ram_wdata_o, ram_wstrb_o, ram_rd_en_o, busy_o, grant_o
    );
endinterface

// File: rtl/ceres_rr_arb2.sv
// ceres_rr_arb2: combinational two-way round-robin pick, i_rr breaks ties
module ceres_rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_rr,
    output logic       o_gnt_vld,
    output logic       o_gnt_idx
);
    assign o_gnt_vld = |i_valid;
    assign o_gnt_idx = &i_valid ? i_rr : i_valid[1];
endmodule

// File: rtl/ceres_ram_arbiter.sv
// ceres_ram_arbiter: two-master arbiter/sequencer for the single synchronous RAM port
module ceres_ram_arbiter
    import ceres_ram_arbiter_pkg::*;
#(
    parameter int RAM_DEPTH   = 32768,
    parameter int LATENCY     = 16,
    parameter int BYTE_OFFSET = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ceres_ram_arbiter_if.slave bus
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam logic [RAM_ARB_LAT_W-1:0] LAT_M1 = RAM_ARB_LAT_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 255) begin : g_lat_chk
        $error("ceres_ram_arbiter: LATENCY must be in 1..255");
    end

    ram_arb_state_e            r_state, w_next;
    logic                      r_rr, r_owner;
    logic [AW-1:0]             r_addr;
    logic [BLK_SIZE-1:0]       r_wdata, r_rdata;
    logic [BLK_SIZE/8-1:0]     r_rw;
    logic [RAM_ARB_LAT_W-1:0]  r_cnt;
    logic                      w_gnt_vld, w_gnt_idx, w_idle, w_issue, w_busy, w_resp;

    ceres_rr_arb2 u_arb (
        .i_valid   ({bus.m1_req_i.valid, bus.m0_req_i.valid}),
        .i_rr      (r_rr),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_idle  = r_state == IDLE;
    assign w_issue = r_state == ISSUE;
    assign w_busy  = !w_idle;
    // a response is only offered while the owner still holds its request
    assign w_resp  = r_state == RESP && (r_owner ? bus.m1_req_i.valid : bus.m0_req_i.valid);

    // state register
    always_ff @(posedge clk_i) begin
        r_state <= !rst_ni ? IDLE : w_next;
    end

    // request latch, latency counter, read-data capture and round-robin pointer
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr    <= 1'b0;
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rw    <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_idle && w_gnt_vld) begin
                r_owner <= w_gnt_idx;
                r_addr  <= w_gnt_idx ? bus.m1_req_i.addr[BYTE_OFFSET+AW-1:BYTE_OFFSET]
                                     : bus.m0_req_i.addr[BYTE_OFFSET+AW-1:BYTE_OFFSET];
                r_wdata <= w_gnt_idx ? bus.m1_req_i.data : bus.m0_req_i.data;
                r_rw    <= w_gnt_idx ? bus.m1_req_i.rw : bus.m0_req_i.rw;
            end
            if (w_issue) r_cnt <= LAT_M1;
            if (r_state == WAIT) begin
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                if (r_cnt == LAT_M1) r_rdata <= bus.ram_rdata_i;
                if (r_cnt == '0) r_rr <= ~r_owner;
            end
        end
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_gnt_vld ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = r_cnt == '0 ? RESP : WAIT;
            default: w_next = IDLE;
        endcase
    end

    // master responses, RAM port and status outputs
    always_comb begin
        bus.m0_res_o       = '0;
        bus.m1_res_o       = '0;
        bus.m0_res_o.ready = w_idle && w_gnt_vld && !w_gnt_idx;
        bus.m1_res_o.ready = w_idle && w_gnt_vld && w_gnt_idx;
        bus.m0_res_o.valid = w_resp && !r_owner;
        bus.m1_res_o.valid = w_resp && r_owner;
        bus.m0_res_o.data  = (w_resp && !r_owner) ? r_rdata : '0;
        bus.m1_res_o.data  = (w_resp && r_owner) ? r_rdata : '0;
        bus.ram_addr_o     = w_issue ? r_addr : '0;
        bus.ram_wdata_o    = w_issue ? r_wdata : '0;
        bus.ram_wstrb_o    = w_issue ? r_rw : '0;
        bus.ram_rd_en_o    = w_issue && r_rw == '0;
        bus.busy_o         = w_busy;
        bus.grant_o        = w_busy && r_owner;
    end
endmodule

// File: tb/tb_ceres_ram_arbiter.sv
// tb_ceres_ram_arbiter: scoreboard bench for the two-master RAM arbiter
module tb_ceres_ram_arbiter;
    import ceres_ram_arbiter_pkg::*;

    localparam int AW = 15;

    typedef struct {
        bit          m;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [31:0] mem_a [1024];
    bit          wr_a  [1024];
    logic [31:0] mem_b [1024];
    bit          wr_b  [1024];

    ceres_ram_arbiter_if #(.AW(AW)) bus_a ();
    ceres_ram_arbiter_if #(.AW(AW)) bus_b ();

    ceres_ram_arbiter #(.LATENCY(16)) u_dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a.slave));
    ceres_ram_arbiter #(.LATENCY(1))  u_dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [9:0] a);
        return a == 10'd4 ? 32'hDEADBEEF : a == 10'd5 ? 32'h0BADF00D : {16'hC0DE, 6'h0, a};
    endfunction

    function automatic iomem_req_t rd(input logic [31:0] addr);
        return '{valid: 1'b1, addr: addr, data: 32'h0, rw: 4'h0};
    endfunction

    function automatic iomem_req_t wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] rw);
        return '{valid: 1'b1, addr: addr, data: data, rw: rw};
    endfunction

    // synchronous RAM models: read-before-write, poisoned data when not accessed
    always @(posedge clk) begin
        logic [31:0] cur;
        cur = wr_a[bus_a.ram_addr_o[9:0]] ? mem_a[bus_a.ram_addr_o[9:0]] : init_word(bus_a.ram_addr_o[9:0]);
        bus_a.ram_rdata_i <= (bus_a.ram_rd_en_o || |bus_a.ram_wstrb_o) ? cur : 32'hBAD0BAD0;
        if (|bus_a.ram_wstrb_o) begin
            for (int i = 0; i < 4; i++) if (bus_a.ram_wstrb_o[i]) cur[8*i+:8] = bus_a.ram_wdata_o[8*i+:8];
            mem_a[bus_a.ram_addr_o[9:0]] <= cur;
            wr_a[bus_a.ram_addr_o[9:0]]  <= 1'b1;
        end
    end

    always @(posedge clk) begin
        logic [31:0] cur;
        cur = wr_b[bus_b.ram_addr_o[9:0]] ? mem_b[bus_b.ram_addr_o[9:0]] : init_word(bus_b.ram_addr_o[9:0]);
        bus_b.ram_rdata_i <= (bus_b.ram_rd_en_o || |bus_b.ram_wstrb_o) ? cur : 32'hBAD0BAD0;
        if (|bus_b.ram_wstrb_o) begin
            for (int i = 0; i < 4; i++) if (bus_b.ram_wstrb_o[i]) cur[8*i+:8] = bus_b.ram_wdata_o[8*i+:8];
            mem_b[bus_b.ram_addr_o[9:0]] <= cur;
            wr_b[bus_b.ram_addr_o[9:0]]  <= 1'b1;
        end
    end

    // response monitor for the LATENCY=16 instance: every valid pops the scoreboard
    always @(negedge clk) begin
        exp_t        e;
        bit          got_m;
        logic [31:0] got_d;
        if (bus_a.m0_res_o.valid === 1'b1 || bus_a.m1_res_o.valid === 1'b1) begin
            checks++;
            got_m = bus_a.m1_res_o.valid === 1'b1;
            got_d = got_m ? bus_a.m1_res_o.data : bus_a.m0_res_o.data;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got m%0d data=%h at cycle %0d, required no response", got_m, got_d, cyc);
            end else begin
                e = sb.pop_front();
                if ({bus_a.m0_res_o.valid, bus_a.m1_res_o.valid, got_d, cyc} !== {!e.m, e.m, e.data, e.cyc}) begin
                    errors++;
                    $display("FAIL resp: got m0v=%b m1v=%b data=%h cycle=%0d, required m%0d data=%h cycle=%0d",
                             bus_a.m0_res_o.valid, bus_a.m1_res_o.valid, got_d, cyc, e.m, e.data, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit m);
        int n = 0;
        @(negedge clk);
        while ((m ? bus_a.m1_res_o.valid : bus_a.m0_res_o.valid) !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout m%0d: got no valid within 60 cycles, required a response", m);
        end
        #1;
        if (m) bus_a.m1_req_i = '0;
        else bus_a.m0_req_i = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.m0_req_i = '0;
        bus_a.m1_req_i = '0;
        bus_b.m0_req_i = '0;
        bus_b.m1_req_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_a.busy_o, bus_a.grant_o, bus_a.m0_res_o, bus_a.m1_res_o, bus_a.ram_rd_en_o,
             bus_a.ram_wstrb_o, bus_a.ram_addr_o, bus_a.ram_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_a: got busy=%b grant=%b m0=%h m1=%h rd=%b strb=%h, required all 0",
                     bus_a.busy_o, bus_a.grant_o, bus_a.m0_res_o, bus_a.m1_res_o, bus_a.ram_rd_en_o, bus_a.ram_wstrb_o);
        end
        checks++;
        if ({bus_b.busy_o, bus_b.grant_o, bus_b.m0_res_o, bus_b.m1_res_o, bus_b.ram_rd_en_o,
             bus_b.ram_wstrb_o, bus_b.ram_addr_o, bus_b.ram_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_b: got busy=%b grant=%b m0=%h m1=%h rd=%b strb=%h, required all 0",
                     bus_b.busy_o, bus_b.grant_o, bus_b.m0_res_o, bus_b.m1_res_o, bus_b.ram_rd_en_o, bus_b.ram_wstrb_o);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        int t;
        tick();
        t = cyc;
        bus_a.m0_req_i = rd(32'h8000_0010);
        sb.push_back('{1'b0, 32'hDEADBEEF, t + 18});
        @(negedge clk);
        checks++;
        if ({bus_a.m0_res_o.ready, bus_a.m1_res_o} !== {1'b1, 34'h0}) begin
            errors++;
            $display("FAIL read_ready: got m0rdy=%b m1=%h, required 1 and 0", bus_a.m0_res_o.ready, bus_a.m1_res_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus_a.ram_rd_en_o, bus_a.ram_addr_o, bus_a.ram_wstrb_o, bus_a.busy_o, bus_a.grant_o} !== {1'b1, 15'd4, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL read_issue: got rd=%b addr=%0d strb=%h busy=%b grant=%b, required 1 4 0 1 0",
                     bus_a.ram_rd_en_o, bus_a.ram_addr_o, bus_a.ram_wstrb_o, bus_a.busy_o, bus_a.grant_o);
        end
        for (int k = 2; k < 18; k++) begin
            @(negedge clk);
            checks++;
            if ({bus_a.ram_rd_en_o, bus_a.ram_wstrb_o, bus_a.m0_res_o.valid, bus_a.m1_res_o} !== '0) begin
                errors++;
                $display("FAIL read_quiet T+%0d: got rd=%b strb=%h m0v=%b m1=%h, required all 0",
                         k, bus_a.ram_rd_en_o, bus_a.ram_wstrb_o, bus_a.m0_res_o.valid, bus_a.m1_res_o);
            end
        end
        wait_resp(1'b0);
    endtask

    task automatic test_arbitration();
        int t;
        test_reset();
        for (int p = 0; p < 2; p++) begin
            tick();
            t = cyc;
            bus_a.m0_req_i = rd(32'h8000_0010);
            bus_a.m1_req_i = rd(32'h8000_0014);
            sb.push_back('{1'b0, 32'hDEADBEEF, t + 18});
            sb.push_back('{1'b1, 32'h0BADF00D, t + 37});
            @(negedge clk);
            checks++;
            if ({bus_a.m0_res_o.ready, bus_a.m1_res_o.ready} !== 2'b10) begin
                errors++;
                $display("FAIL arb_first pair%0d: got m0rdy=%b m1rdy=%b, required 1 0", p, bus_a.m0_res_o.ready, bus_a.m1_res_o.ready);
            end
            for (int k = 1; k < 18; k++) begin
                @(negedge clk);
                checks++;
                if (bus_a.m1_res_o !== '0) begin
                    errors++;
                    $display("FAIL arb_m1_held pair%0d T+%0d: got m1=%h, required 0", p, k, bus_a.m1_res_o);
                end
            end
            wait_resp(1'b0);
            @(negedge clk);
            checks++;
            if ({bus_a.m1_res_o.ready, bus_a.m0_res_o.ready, bus_a.busy_o} !== 3'b100) begin
                errors++;
                $display("FAIL arb_second pair%0d: got m1rdy=%b m0rdy=%b busy=%b, required 1 0 0",
                         p, bus_a.m1_res_o.ready, bus_a.m0_res_o.ready, bus_a.busy_o);
            end
            wait_resp(1'b1);
        end
    endtask

    task automatic test_write();
        int t;
        tick();
        t = cyc;
        bus_a.m1_req_i = wr(32'h8000_0020, 32'h1234_5678, 4'hF);
        sb.push_back('{1'b1, 32'hC0DE0008, t + 18});
        @(negedge clk);
        checks++;
        if ({bus_a.m1_res_o.ready, bus_a.m0_res_o} !== {1'b1, 34'h0}) begin
            errors++;
            $display("FAIL write_ready: got m1rdy=%b m0=%h, required 1 and 0", bus_a.m1_res_o.ready, bus_a.m0_res_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus_a.ram_wstrb_o, bus_a.ram_rd_en_o, bus_a.ram_addr_o, bus_a.ram_wdata_o, bus_a.grant_o} !==
            {4'hF, 1'b0, 15'd8, 32'h1234_5678, 1'b1}) begin
            errors++;
            $display("FAIL write_issue: got strb=%h rd=%b addr=%0d wdata=%h grant=%b, required f 0 8 12345678 1",
                     bus_a.ram_wstrb_o, bus_a.ram_rd_en_o, bus_a.ram_addr_o, bus_a.ram_wdata_o, bus_a.grant_o);
        end
        for (int k = 2; k < 18; k++) begin
            @(negedge clk);
            checks++;
            if ({bus_a.ram_wstrb_o, bus_a.ram_rd_en_o} !== 5'h0) begin
                errors++;
                $display("FAIL write_quiet T+%0d: got strb=%h rd=%b, required 0 0", k, bus_a.ram_wstrb_o, bus_a.ram_rd_en_o);
            end
        end
        wait_resp(1'b1);
        tick();
        t = cyc;
        bus_a.m0_req_i = rd(32'h8000_0020);
        sb.push_back('{1'b0, 32'h1234_5678, t + 18});
        wait_resp(1'b0);
    endtask

    task automatic test_drop();
        int t;
        tick();
        t = cyc;
        bus_a.m0_req_i = rd(32'h8000_0010);
        repeat (5) tick();
        bus_a.m0_req_i = '0;
        bus_a.m1_req_i = rd(32'h8000_0014);
        sb.push_back('{1'b1, 32'h0BADF00D, t + 37});
        @(negedge clk);
        checks++;
        if (bus_a.m1_res_o.ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_pending: got m1rdy=%b, required 0", bus_a.m1_res_o.ready);
        end
        for (int k = 6; k <= 18; k++) begin
            @(negedge clk);
            checks++;
            if ({bus_a.m0_res_o, bus_a.m1_res_o, bus_a.busy_o} !== {68'h0, 1'b1}) begin
                errors++;
                $display("FAIL drop_quiet T+%0d: got m0=%h m1=%h busy=%b, required 0 0 1", k, bus_a.m0_res_o, bus_a.m1_res_o, bus_a.busy_o);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus_a.m1_res_o.ready, bus_a.busy_o} !== 2'b10) begin
            errors++;
            $display("FAIL drop_regrant: got m1rdy=%b busy=%b at T+%0d, required 1 0", bus_a.m1_res_o.ready, bus_a.busy_o, cyc - t);
        end
        wait_resp(1'b1);
    endtask

    task automatic test_reset_mid();
        int t;
        tick();
        bus_a.m0_req_i = rd(32'h8000_0014);
        repeat (5) tick();
        rst_n = 1'b0;
        bus_a.m0_req_i = '0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_a.busy_o, bus_a.grant_o, bus_a.m0_res_o, bus_a.m1_res_o, bus_a.ram_rd_en_o, bus_a.ram_wstrb_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b grant=%b m0=%h m1=%h rd=%b strb=%h, required all 0",
                     bus_a.busy_o, bus_a.grant_o, bus_a.m0_res_o, bus_a.m1_res_o, bus_a.ram_rd_en_o, bus_a.ram_wstrb_o);
        end
        tick();
        t = cyc;
        bus_a.m1_req_i = rd(32'h8000_0010);
        sb.push_back('{1'b1, 32'hDEADBEEF, t + 18});
        @(negedge clk);
        checks++;
        if ({bus_a.m1_res_o.ready, bus_a.m0_res_o.ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_lone_m1: got m1rdy=%b m0rdy=%b, required 1 0", bus_a.m1_res_o.ready, bus_a.m0_res_o.ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus_a.busy_o, bus_a.grant_o} !== 2'b11) begin
            errors++;
            $display("FAIL reset_grant: got busy=%b grant=%b, required 1 1", bus_a.busy_o, bus_a.grant_o);
        end
        wait_resp(1'b1);
    endtask

    task automatic test_latency1();
        tick();
        bus_b.m0_req_i = rd(32'h8000_000C);
        @(negedge clk);
        checks++;
        if ({bus_b.m0_res_o.ready, bus_b.m0_res_o.valid} !== 2'b10) begin
            errors++;
            $display("FAIL lat1_grant: got rdy=%b valid=%b, required 1 0", bus_b.m0_res_o.ready, bus_b.m0_res_o.valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus_b.ram_rd_en_o, bus_b.ram_addr_o, bus_b.m0_res_o.valid} !== {1'b1, 15'd3, 1'b0}) begin
            errors++;
            $display("FAIL lat1_issue: got rd=%b addr=%0d valid=%b, required 1 3 0", bus_b.ram_rd_en_o, bus_b.ram_addr_o, bus_b.m0_res_o.valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus_b.m0_res_o.valid, bus_b.busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL lat1_wait: got valid=%b busy=%b, required 0 1", bus_b.m0_res_o.valid, bus_b.busy_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus_b.m0_res_o.valid, bus_b.m0_res_o.data, bus_b.m1_res_o.valid} !== {1'b1, 32'hC0DE0003, 1'b0}) begin
            errors++;
            $display("FAIL lat1_resp: got valid=%b data=%h m1v=%b, required 1 c0de0003 0",
                     bus_b.m0_res_o.valid, bus_b.m0_res_o.data, bus_b.m1_res_o.valid);
        end
        #1;
        bus_b.m0_req_i = '0;
        tick();
        @(negedge clk);
        checks++;
        if ({bus_b.busy_o, bus_b.m0_res_o} !== '0) begin
            errors++;
            $display("FAIL lat1_idle: got busy=%b m0=%h, required 0 0", bus_b.busy_o, bus_b.m0_res_o);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_arbitration();
        test_write();
        test_drop();
        test_reset_mid();
        test_latency1();
        repeat (3) tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending responses, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
